// File: rtl/multdiv_unit.sv
// Multi-cycle signed 32-bit multiply/divide unit for the execute stage.
// Build option: define MULTDIV_BOOTH4_EN for a 16-iteration radix-4 Booth multiply.
module multdiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);

  // Handshake: ctrl_MULT/ctrl_DIV is sampled on every rising edge and always
  // accepted (restarting any operation in flight); data_resultRDY is a one-cycle
  // strobe with data_result/data_exception valid; busy covers start..strobe.
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

`ifdef MULTDIV_BOOTH4_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(15);
`else
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(31);
`endif
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(31);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       op_a_q, op_b_q;
  logic              op_mul_q;
  logic [31:0]       mcand_q;
  logic [63:0]       prod_q;
  logic [31:0]       result_q;
  logic              exc_q;
  logic              rdy_q;
  logic              start;

  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  assign start = ctrl_MULT | ctrl_DIV;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        MUL:     state_d = (cnt_q == MUL_LAST) ? DONE : MUL;
        DIV:     state_d = (cnt_q == DIV_LAST) ? DONE : DIV;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q != IDLE) || rdy_q;
    data_resultRDY = rdy_q;
    data_result    = result_q;
    data_exception = exc_q;
  end

  // Radix-2 multiply step: accumulate into the high half, shift right.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);

  // Restoring divide step: remainder in prod_q[63:32], quotient shifts into [31:0].
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  assign div_sh  = {prod_q[63:32], prod_q[31]};
  assign div_ge  = div_sh >= {1'b0, mcand_q};
  assign div_sub = div_sh[31:0] - mcand_q;

`ifdef MULTDIV_BOOTH4_EN
  logic [63:0] booth_mc_q;
  logic [32:0] booth_mp_q;
  logic [63:0] booth_add;

  always_comb begin
    booth_add = 64'd0;
    case (booth_mp_q[2:0])
      3'b001, 3'b010: booth_add = booth_mc_q;
      3'b011:         booth_add = booth_mc_q << 1;
      3'b100:         booth_add = -(booth_mc_q << 1);
      3'b101, 3'b110: booth_add = -booth_mc_q;
      default:        booth_add = 64'd0;
    endcase
  end
`endif

  // Final sign correction and exception detection, captured on leaving DONE.
  logic        neg;
  logic [63:0] fin_prod;
  logic [31:0] fin_quo;
  logic [31:0] fin_res;
  logic        fin_exc;

  always_comb begin
    neg = op_a_q[31] ^ op_b_q[31];
`ifdef MULTDIV_BOOTH4_EN
    fin_prod = prod_q;
`else
    fin_prod = neg ? -prod_q : prod_q;
`endif
    fin_quo = neg ? -prod_q[31:0] : prod_q[31:0];
    fin_res = fin_quo;
    fin_exc = 1'b0;
    if (op_mul_q) begin
      fin_res = fin_prod[31:0];
      fin_exc = !((&fin_prod[63:31]) || (~|fin_prod[63:31]));
    end else if (op_b_q == 32'd0) begin
      fin_res = 32'd0;
      fin_exc = 1'b1;
    end else if (op_a_q == 32'h8000_0000 && op_b_q == 32'hFFFF_FFFF) begin
      fin_res = 32'h8000_0000;
      fin_exc = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_mul_q   <= 1'b0;
      mcand_q    <= '0;
      prod_q     <= '0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      booth_mc_q <= '0;
      booth_mp_q <= '0;
`endif
    end else begin
      rdy_q <= (state_q == DONE);
      if (state_q == DONE) begin
        result_q <= fin_res;
        exc_q    <= fin_exc;
      end
      if (start) begin
        op_a_q   <= data_operandA;
        op_b_q   <= data_operandB;
        op_mul_q <= ctrl_MULT;
        cnt_q    <= '0;
        mcand_q  <= ctrl_MULT ? mag(data_operandA) : mag(data_operandB);
        if (ctrl_MULT) begin
`ifdef MULTDIV_BOOTH4_EN
          prod_q     <= 64'd0;
          booth_mc_q <= {{32{data_operandA[31]}}, data_operandA};
          booth_mp_q <= {data_operandB, 1'b0};
`else
          prod_q     <= {32'd0, mag(data_operandB)};
`endif
        end else begin
          prod_q <= {32'd0, mag(data_operandA)};
        end
      end else if (state_q == MUL) begin
        cnt_q <= (cnt_q == MUL_LAST) ? '0 : cnt_q + CNT_W'(1);
`ifdef MULTDIV_BOOTH4_EN
        prod_q     <= prod_q + booth_add;
        booth_mc_q <= booth_mc_q << 2;
        booth_mp_q <= {{2{booth_mp_q[32]}}, booth_mp_q[32:2]};
`else
        prod_q     <= {mul_sum, prod_q[31:1]};
`endif
      end else if (state_q == DIV) begin
        cnt_q  <= (cnt_q == DIV_LAST) ? '0 : cnt_q + CNT_W'(1);
        prod_q <= {(div_ge ? div_sub : div_sh[31:0]), prod_q[30:0], div_ge};
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: vector table plus abort and reset sequences.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    bit          is_mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[$];

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] r, input logic e);
    vec_t v;
    v.is_mul = m; v.a = a; v.b = b; v.res = r; v.exc = e;
    vecs.push_back(v);
  endfunction

  // Waits (bounded) for the strobe after a start edge; returns posedges counted.
  task automatic wait_rdy(output int edges, output int busy_low);
    edges = 0;
    busy_low = 0;
    while (data_resultRDY !== 1'b1 && edges < 100) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clock);
      edges++;
      @(negedge clock);
    end
    if (busy !== 1'b1) busy_low++;
  endtask

  task automatic run_op(input bit is_mul, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] er, input logic ee, input string tag);
    int edges, busy_low;
    logic [31:0] exp_res;
    exp_q.push_back(er);
    @(negedge clock);
    data_operandA = oa;
    data_operandB = ob;
    ctrl_MULT = is_mul;
    ctrl_DIV  = !is_mul;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    wait_rdy(edges, busy_low);
    exp_res = exp_q.pop_front();
    chk({tag, " latency"}, 32'(edges), 32'(is_mul ? MUL_LAT : DIV_LAT));
    chk({tag, " busy_gap"}, 32'(busy_low), 32'd0);
    chk({tag, " result"}, data_result, exp_res);
    chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, ee});
    @(negedge clock);
    chk({tag, " rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
    chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, " result_hold"}, data_result, exp_res);
  endtask

  initial begin
    int edges, busy_low, strobes;

    add_vec(1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    add_vec(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    add_vec(1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
    add_vec(1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, 1'b0);
    add_vec(1, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1);
    add_vec(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    add_vec(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    add_vec(1, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
    add_vec(1, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0);
    add_vec(1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0);
    add_vec(0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
    add_vec(0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0);
    add_vec(0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1);
    add_vec(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    add_vec(0, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
    add_vec(0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0);
    add_vec(0, 32'h0000_0003, 32'h0000_000A, 32'h0000_0000, 1'b0);
    add_vec(0, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0);
    add_vec(0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0);
    add_vec(0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0000, 1'b1);

    // Clock/reset block
    reset = 1'b1;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset result", data_result, 32'd0);
    chk("reset exception", {31'd0, data_exception}, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i])
      run_op(vecs[i].is_mul, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc,
             $sformatf("vec%0d", i));

    // Abort: multiply 3x4, then divide 100/7 ten cycles later.
    strobes = 0;
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) begin
      if (data_resultRDY === 1'b1) strobes++;
      @(negedge clock);
    end
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_rdy(edges, busy_low);
    chk("abort latency", 32'(edges), 32'(DIV_LAT));
    chk("abort busy_gap", 32'(busy_low), 32'd0);
    chk("abort result", data_result, 32'h0000_000E);
    chk("abort exception", {31'd0, data_exception}, 32'd0);
    if (data_resultRDY === 1'b1) strobes++;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) strobes++;
    end
    chk("abort strobe_count", 32'(strobes), 32'd1);

    // Reset mid-divide clears everything at once and suppresses the strobe.
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (19) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midreset result", data_result, 32'd0);
    chk("midreset exception", {31'd0, data_exception}, 32'd0);
    chk("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    strobes = 0;
    repeat (50) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1 || busy === 1'b1) strobes++;
    end
    chk("midreset no_strobe", 32'(strobes), 32'd0);
    run_op(0, 32'd9, 32'd3, 32'd3, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
